lut_mac_sequencer: RTL

Sequencer for the bit-serial LUT multiply-accumulate path. It builds the 8-entry, 128-bit partial-sum LUT from three activations and drives the 3-bit select of the external 8-to-1 LUT mux with one weight bit-plane per cycle. It shift-accumulates the returned 16-bit entries into a dot-product result for three activation/weight pairs, with a valid/ready result handshake. It sits between the PE-array operand feed and the LUT mux.

---
 rtl/lut_mac_sequencer_pkg.sv | 22 ++
 rtl/lut_mac_sequencer_lut_builder.sv | 27 ++
 rtl/lut_mac_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lut_mac_sequencer_pkg.sv
// Shared types and sizes for the bit-serial LUT multiply-accumulate sequencer.
package lut_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int LUT_ENTRIES = 8;
    localparam int ENTRY_W     = 16;
    localparam int ACT_W       = 8;
    localparam int CTRL_W      = 3;
    localparam int LUT_W       = LUT_ENTRIES * ENTRY_W;

    // Sign-extend one activation to LUT entry width.
    function automatic logic signed [ENTRY_W-1:0] sext_act(input logic signed [ACT_W-1:0] a);
        return ENTRY_W'(a);
    endfunction

endpackage

// File: rtl/lut_mac_sequencer_lut_builder.sv
// Combinational subset-sum generator: entry k holds the sum of the
// activations whose index bit is set in k (entry 0 is zero).
module lut_builder
    import lut_mac_sequencer_pkg::*;
(
    input  logic signed [ACT_W-1:0] i_act0,
    input  logic signed [ACT_W-1:0] i_act1,
    input  logic signed [ACT_W-1:0] i_act2,
    output logic [LUT_W-1:0]        o_lut
);

    logic signed [ENTRY_W-1:0] w_sum;

    // Build all eight subset sums; the +-384 range always fits in 16 bits.
    always_comb begin
        o_lut = '0;
        w_sum = '0;
        for (int k = 0; k < LUT_ENTRIES; k++) begin
            w_sum = '0;
            if (k[0]) w_sum = w_sum + sext_act(i_act0);
            if (k[1]) w_sum = w_sum + sext_act(i_act1);
            if (k[2]) w_sum = w_sum + sext_act(i_act2);
            o_lut[k*ENTRY_W +: ENTRY_W] = w_sum;
        end
    end

endmodule

// File: rtl/lut_mac_sequencer.sv
// Bit-serial LUT MAC sequencer: captures three activation/weight pairs,
// registers the partial-sum LUT, walks the weight bit-planes through the
// external LUT mux and shift-accumulates the returned entries.
// Build option: SIGNED_WEIGHT_EN treats weights as two's complement
// (top plane subtracted); undefined means unsigned weights.
//
// state | meaning
// IDLE  | waiting for start, operands captured on start
// LOAD  | LUT registered, accumulator and plane counter cleared
// RUN   | one weight bit-plane per cycle, mux_data accumulated
// DONE  | result presented until out_ready
module lut_mac_sequencer
    import lut_mac_sequencer_pkg::*;
#(
    parameter int WBITS = 8,
    parameter int ACC_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [ACT_W-1:0]  act0,
    input  logic signed [ACT_W-1:0]  act1,
    input  logic signed [ACT_W-1:0]  act2,
    input  logic [WBITS-1:0]         w0,
    input  logic [WBITS-1:0]         w1,
    input  logic [WBITS-1:0]         w2,
    output logic                     busy,
    output logic [LUT_W-1:0]         lut_out,
    output logic [CTRL_W-1:0]        mux_ctrl,
    input  logic [ENTRY_W-1:0]       mux_data,
    output logic signed [ACC_W-1:0]  result,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int PW = (WBITS > 1) ? $clog2(WBITS) : 1;
    localparam logic [PW-1:0] LAST_PLANE = PW'(WBITS - 1);

    state_t                    r_state;
    logic signed [ACT_W-1:0]   r_act0, r_act1, r_act2;
    logic [WBITS-1:0]          r_w0, r_w1, r_w2;
    logic [PW-1:0]             r_plane;
    logic signed [ACC_W-1:0]   r_acc;
    logic [LUT_W-1:0]          r_lut;
    logic [CTRL_W-1:0]         r_mux_ctrl;
    logic signed [ACC_W-1:0]   r_result;
    logic                      r_out_valid;
    logic                      r_busy;

    logic [LUT_W-1:0]          w_lut;
    logic signed [ACC_W-1:0]   w_ext;
    logic signed [ACC_W-1:0]   w_term;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic                      w_last;
    logic [PW-1:0]             w_plane_nxt;
    logic [CTRL_W-1:0]         w_ctrl_nxt;

    lut_builder u_lut_builder (
        .i_act0 (r_act0),
        .i_act1 (r_act1),
        .i_act2 (r_act2),
        .o_lut  (w_lut)
    );

    // Shifted, sign-extended mux return and the next accumulator value.
    always_comb begin
        w_ext       = ACC_W'($signed(mux_data));
        w_term      = w_ext <<< r_plane;
        w_last      = (r_plane == LAST_PLANE);
        w_plane_nxt = r_plane + PW'(1);
        w_ctrl_nxt  = {r_w2[w_plane_nxt], r_w1[w_plane_nxt], r_w0[w_plane_nxt]};
`ifdef SIGNED_WEIGHT_EN
        w_acc_nxt   = w_last ? (r_acc - w_term) : (r_acc + w_term);
`else
        w_acc_nxt   = r_acc + w_term;
`endif
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_act0      <= '0;
            r_act1      <= '0;
            r_act2      <= '0;
            r_w0        <= '0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_plane     <= '0;
            r_acc       <= '0;
            r_lut       <= '0;
            r_mux_ctrl  <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_act0  <= act0;
                        r_act1  <= act1;
                        r_act2  <= act2;
                        r_w0    <= w0;
                        r_w1    <= w1;
                        r_w2    <= w2;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_lut      <= w_lut;
                    r_acc      <= '0;
                    r_plane    <= '0;
                    r_mux_ctrl <= {r_w2[0], r_w1[0], r_w0[0]};
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_mux_ctrl  <= '0;
                        r_result    <= w_acc_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_plane    <= w_plane_nxt;
                        r_mux_ctrl <= w_ctrl_nxt;
                    end
                end
                ST_DONE: begin
                    // start in the handshake cycle is deliberately dropped
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign lut_out   = r_lut;
    assign mux_ctrl  = r_mux_ctrl;
    assign result    = r_result;
    assign out_valid = r_out_valid;

endmodule
